omsp_spm_cmd_seq: RTL and testbench

OMSP_SPM_CMD_SEQ -- requirements
Module: omsp_spm_cmd_seq

---
 rtl/omsp_spm_cmd_seq.sv | 154 +++++++++++++++
 tb/tb_omsp_spm_cmd_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/omsp_spm_cmd_seq.sv
// omsp_spm_cmd_seq: command sequencer that sits between the execution unit
// and the SPM array. It handles protect/unprotect (an update strobe followed
// by a violation check) and key loads (KEY_WORDS 16-bit words streamed to the
// array). Each command ends with a one-cycle done pulse and a held status.
module omsp_spm_cmd_seq #(
    parameter int KEY_WORDS = 8
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic        cmd_abort,
    input  logic [15:0] key_word,
    input  logic        key_word_valid,
    output logic        key_word_ready,
    input  logic        spm_key_select_valid,
    input  logic        spm_violation,
    output logic        update_spm,
    output logic        enable_spm,
    output logic        write_key,
    output logic [15:0] key_in,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status
);

    // A single-word key still needs a 1-bit counter to keep the types legal.
    localparam int CNT_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_WORDS - 1);

    localparam logic [1:0] OP_PROTECT   = 2'b00;
    localparam logic [1:0] OP_UNPROTECT = 2'b01;
    localparam logic [1:0] OP_LOAD_KEY  = 2'b10;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_VIOLATION = 2'b01;
    localparam logic [1:0] ST_ILLEGAL   = 2'b10;
    localparam logic [1:0] ST_ABORTED   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPDATE,
        S_CHECK,
        S_KEY_LOAD,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       status_q, status_d;

    // State, latched opcode, key word counter and result code.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_PROTECT;
            cnt_q    <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

    // Next-state logic and strobes; status only changes on the way into RESP
    // so it stays stable from one response to the next.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        cnt_d          = cnt_q;
        status_d       = status_q;
        cmd_ready      = 1'b0;
        key_word_ready = 1'b0;
        update_spm     = 1'b0;
        enable_spm     = 1'b0;
        write_key      = 1'b0;
        key_in         = '0;
        done           = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d = cmd_op;
                    case (cmd_op)
                        OP_PROTECT, OP_UNPROTECT: begin
                            state_d = S_UPDATE;
                        end
                        OP_LOAD_KEY: begin
                            if (spm_key_select_valid) begin
                                cnt_d   = '0;
                                state_d = S_KEY_LOAD;
                            end else begin
                                status_d = ST_ILLEGAL;
                                state_d  = S_RESP;
                            end
                        end
                        default: begin
                            status_d = ST_ILLEGAL;
                            state_d  = S_RESP;
                        end
                    endcase
                end
            end

            S_UPDATE: begin
                update_spm = 1'b1;
                enable_spm = (op_q == OP_PROTECT);
                state_d    = S_CHECK;
            end

            S_CHECK: begin
                status_d = spm_violation ? ST_VIOLATION : ST_OK;
                state_d  = S_RESP;
            end

            S_KEY_LOAD: begin
                // Abort wins over a word offered in the same cycle.
                if (cmd_abort) begin
                    status_d = ST_ABORTED;
                    state_d  = S_RESP;
                end else if (key_word_valid) begin
                    key_word_ready = 1'b1;
                    write_key      = 1'b1;
                    key_in         = key_word;
                    if (cnt_q == CNT_LAST) begin
                        // Counter is left at its last value rather than wrapping.
                        status_d = ST_OK;
                        state_d  = S_RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_RESP: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign status = status_q;

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Scoreboard bench for omsp_spm_cmd_seq: expected key words and response codes
// are queued when commands are driven and checked as the DUT emits them.
module tb_omsp_spm_cmd_seq;

    localparam int KW = 8;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic        cmd_abort;
    logic [15:0] key_word;
    logic        key_word_valid;
    logic        key_word_ready;
    logic        spm_key_select_valid;
    logic        spm_violation;
    logic        update_spm;
    logic        enable_spm;
    logic        write_key;
    logic [15:0] key_in;
    logic        busy;
    logic        done;
    logic [1:0]  status;

    omsp_spm_cmd_seq #(.KEY_WORDS(KW)) dut (
        .mclk                 (mclk),
        .puc_rst              (puc_rst),
        .cmd_valid            (cmd_valid),
        .cmd_op               (cmd_op),
        .cmd_ready            (cmd_ready),
        .cmd_abort            (cmd_abort),
        .key_word             (key_word),
        .key_word_valid       (key_word_valid),
        .key_word_ready       (key_word_ready),
        .spm_key_select_valid (spm_key_select_valid),
        .spm_violation        (spm_violation),
        .update_spm           (update_spm),
        .enable_spm           (enable_spm),
        .write_key            (write_key),
        .key_in               (key_in),
        .busy                 (busy),
        .done                 (done),
        .status               (status)
    );

    always #5 mclk = ~mclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int upd_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int acc_cyc = 0;

    logic [15:0] exp_key_q[$];
    logic [1:0]  exp_status_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge mclk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every write and every response.
    always @(negedge mclk) begin
        if (!puc_rst) begin
            if (update_spm) upd_cnt++;
            if (write_key) begin
                wr_cnt++;
                if (exp_key_q.size() == 0) check_val("unexpected_write", 32'(key_in), 32'hFFFF_FFFF);
                else check_val("key_in", 32'(key_in), 32'(exp_key_q.pop_front()));
                check_val("key_ready", 32'(key_word_ready), 32'd1);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (exp_status_q.size() == 0) check_val("unexpected_done", 32'd1, 32'd0);
                else check_val("status", 32'(status), 32'(exp_status_q.pop_front()));
            end
            if (update_spm && write_key) check_val("strobe_excl", 32'd1, 32'd0);
            if (!write_key && key_in != 16'h0) check_val("key_in_quiet", 32'(key_in), 32'd0);
        end
    end

    task automatic start_cmd(input logic [1:0] op, input logic sel);
        @(posedge mclk); #1;
        cmd_valid = 1'b1;
        cmd_op = op;
        spm_key_select_valid = sel;
        @(posedge mclk); #1;
        cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    // Offers n words; stall_a/stall_b give word indices followed by a 2-cycle gap.
    task automatic feed_words(input int n, input int stall_a, input int stall_b, input logic rnd);
        for (int i = 0; i < n; i++) begin
            key_word = rnd ? 16'($urandom_range(1, 16'hFFFF)) : 16'(16'h1111 * (i + 1));
            key_word_valid = 1'b1;
            exp_key_q.push_back(key_word);
            @(posedge mclk); #1;
            key_word_valid = 1'b0;
            if (i == stall_a || i == stall_b) begin
                repeat (2) @(posedge mclk);
                #1;
            end
        end
        key_word_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int k = 0;
        while (done_cnt < target && k < 100) begin
            @(negedge mclk);
            k++;
        end
        check_val("done_seen", 32'(done_cnt), 32'(target));
    endtask

    int exp_done = 0;
    int w0, u0, d0;

    initial begin
        puc_rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_abort = 1'b0;
        key_word = 16'h0;
        key_word_valid = 1'b0;
        spm_key_select_valid = 1'b0;
        spm_violation = 1'b0;
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        check_val("rst_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_status", 32'(status), 32'd0);
        check_val("rst_strobes", {29'd0, update_spm, write_key, enable_spm}, 32'd0);
        @(posedge mclk); #1;
        puc_rst = 1'b0;

        // protect, no violation
        exp_status_q.push_back(2'b00);
        start_cmd(2'b00, 1'b0);
        @(negedge mclk);
        check_val("prot_update", 32'(update_spm), 32'd1);
        check_val("prot_enable", 32'(enable_spm), 32'd1);
        check_val("prot_busy", 32'(busy), 32'd1);
        exp_done++; wait_done(exp_done);
        check_val("prot_latency", 32'(done_cyc - acc_cyc), 32'd2);

        // unprotect with violation reported in CHECK
        spm_violation = 1'b1;
        exp_status_q.push_back(2'b01);
        start_cmd(2'b01, 1'b0);
        @(negedge mclk);
        check_val("unprot_update", 32'(update_spm), 32'd1);
        check_val("unprot_enable", 32'(enable_spm), 32'd0);
        exp_done++; wait_done(exp_done);
        spm_violation = 1'b0;

        // key load with stalls after words 3 and 6
        w0 = wr_cnt; u0 = upd_cnt;
        exp_status_q.push_back(2'b00);
        start_cmd(2'b10, 1'b1);
        feed_words(KW, 2, 5, 1'b0);
        exp_done++; wait_done(exp_done);
        check_val("load_writes", 32'(wr_cnt - w0), 32'(KW));
        check_val("load_no_update", 32'(upd_cnt - u0), 32'd0);

        // key load without stalls, random words
        w0 = wr_cnt;
        exp_status_q.push_back(2'b00);
        start_cmd(2'b10, 1'b1);
        feed_words(KW, -1, -1, 1'b1);
        exp_done++; wait_done(exp_done);
        check_val("load_latency", 32'(done_cyc - acc_cyc), 32'(KW));
        check_val("load2_writes", 32'(wr_cnt - w0), 32'(KW));

        // load key with no selected target, then reserved op
        for (int k = 0; k < 2; k++) begin
            w0 = wr_cnt; u0 = upd_cnt;
            exp_status_q.push_back(2'b10);
            start_cmd((k == 0) ? 2'b10 : 2'b11, (k == 0) ? 1'b0 : 1'b1);
            exp_done++; wait_done(exp_done);
            check_val("illegal_strobes", 32'((wr_cnt - w0) + (upd_cnt - u0)), 32'd0);
        end

        // abort after 4 words, with a 5th word offered in the abort cycle
        w0 = wr_cnt;
        exp_status_q.push_back(2'b11);
        start_cmd(2'b10, 1'b1);
        feed_words(4, -1, -1, 1'b0);
        key_word = 16'h5555;
        key_word_valid = 1'b1;
        cmd_abort = 1'b1;
        @(negedge mclk);
        check_val("abort_write", 32'(write_key), 32'd0);
        check_val("abort_ready", 32'(key_word_ready), 32'd0);
        @(posedge mclk); #1;
        cmd_abort = 1'b0;
        key_word_valid = 1'b0;
        exp_done++; wait_done(exp_done);
        check_val("abort_writes", 32'(wr_cnt - w0), 32'd4);

        // protect right after an abort, with cmd_abort held high throughout
        exp_status_q.push_back(2'b00);
        cmd_abort = 1'b1;
        start_cmd(2'b00, 1'b0);
        exp_done++; wait_done(exp_done);
        check_val("prot2_latency", 32'(done_cyc - acc_cyc), 32'd2);
        cmd_abort = 1'b0;

        // leave status at 10 before the reset test
        exp_status_q.push_back(2'b10);
        start_cmd(2'b11, 1'b0);
        exp_done++; wait_done(exp_done);

        // reset in the middle of a key load at counter = 5
        w0 = wr_cnt;
        start_cmd(2'b10, 1'b1);
        feed_words(5, -1, -1, 1'b0);
        puc_rst = 1'b1;
        @(posedge mclk); #1;
        puc_rst = 1'b0;
        @(negedge mclk);
        check_val("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_status", 32'(status), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        d0 = done_cnt;
        key_word = 16'h6666;
        key_word_valid = 1'b1;
        repeat (4) @(negedge mclk);
        key_word_valid = 1'b0;
        check_val("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("mid_rst_writes", 32'(wr_cnt - w0), 32'd5);

        // recovery: unprotect after reset
        exp_status_q.push_back(2'b00);
        start_cmd(2'b01, 1'b0);
        exp_done++; wait_done(exp_done);

        check_val("key_q_empty", 32'(exp_key_q.size()), 32'd0);
        check_val("status_q_empty", 32'(exp_status_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
